sonata_clkgen: RTL and testbench
================================

SONATA_CLKGEN -- requirements
Module: sonata_clkgen

Interface
REQ-001 SHALL have parameter RefClkFreq, default 100_000_000, reference clock frequency in Hz.
REQ-002 SHALL have parameter SysClkFreq, default 50_000_000, system-domain enable rate in Hz.
REQ-003 SHALL have parameter UsbClkFreq, default 48_000_000, USB-domain enable rate in Hz.
REQ-004 SHALL have parameter PeriClkFreq, default 25_000_000, peripheral-domain enable rate in Hz.
REQ-005 SHALL have parameter LockCycles, default 16, number of clk_i cycles from reset release to lock.
REQ-006 SHALL have one clock; reset is synchronous and active-high.
REQ-007 SHALL have port clk_i, input, 1 bit: reference clock, the only clock; all state updates on its rising edge.
REQ-008 SHALL have port rst_i, input, 1 bit: synchronous active-high reset.
REQ-009 SHALL have port clk_sys_en_o, output, 1 bit: system-domain clock enable.
REQ-010 SHALL have port rst_sys_no, output, 1 bit: system-domain reset, active low.
REQ-011 SHALL have port clk_usb_en_o, output, 1 bit: USB-domain clock enable.
REQ-012 SHALL have port rst_usb_no, output, 1 bit: USB-domain reset, active low.
REQ-013 SHALL have port clk_peri_en_o, output, 1 bit: peripheral-domain clock enable.
REQ-014 SHALL have port rst_peri_no, output, 1 bit: peripheral-domain reset, active low.
REQ-015 SHALL have port locked_o, output, 1 bit: high once generation is stable.

Function
REQ-016 SHALL fail elaboration unless each domain frequency F satisfies 0 < F <= RefClkFreq and LockCycles >= 1.
REQ-017 SHALL implement each domain enable as a 32-bit unsigned accumulator acc, starting at 0.
- Per edge: s = acc + F.
- If s >= RefClkFreq: en_o <= 1 and acc <= s - RefClkFreq.
- Otherwise: en_o <= 0 and acc <= s.
REQ-018 SHALL produce, over any RefClkFreq consecutive cycles after reset, exactly F enable pulses per domain; no drift.
REQ-019 SHALL hold clk_x_en_o constantly 1 from the first post-reset edge when F == RefClkFreq.
REQ-020 SHALL run the accumulators from the first edge with rst_i low, independent of locked_o.
REQ-021 SHALL provide a lock counter that increments each edge with rst_i low, saturating at LockCycles.
REQ-022 SHALL register locked_o high on the edge where the lock counter reaches LockCycles; it stays high until rst_i.
REQ-023 SHALL give each domain a 2-stage reset shift register.
- Cleared while locked_o is 0.
- Shifts in 1 only on edges where locked_o is 1 and that domain's registered clk_x_en_o is 1.
- rst_x_no = stage 2, so release occurs on the 2nd enabled edge after lock.
REQ-024 SHALL never reassert a domain reset after release except through rst_i.
REQ-025 SHALL let domain resets release independently, each aligned to its own enable; no inter-domain ordering.

Reset
REQ-026 SHALL, on any edge with rst_i high, set: all accumulators 0, all clk_x_en_o 0, lock counter 0, locked_o 0, all reset shift registers 0 (rst_x_no 0).
REQ-027 SHALL apply REQ-026 identically when rst_i asserts mid-operation; outputs reach reset values on that same edge.
REQ-028 SHALL restart the full sequence of REQ-017..REQ-023 from the first edge after rst_i deasserts.

Verification
REQ-029 Defaults, rst_i high 3 cycles then low -> clk_sys_en_o sequence 0,1,0,1,...; clk_peri_en_o 0,0,0,1 repeating.
REQ-030 Defaults, 25 edges after reset release -> clk_usb_en_o high exactly 12 times; first pulse on 3rd edge (acc 48,96,44).
REQ-031 Defaults -> locked_o rises on 16th edge after release; rst_sys_no rises on 2nd sys enable after lock; rst_peri_no rises after rst_sys_no.
REQ-032 SysClkFreq=RefClkFreq -> clk_sys_en_o 1 every edge after release; rst_sys_no high 2 edges after locked_o.
REQ-033 Full sequence complete, then rst_i pulsed 1 cycle -> same edge: all enables 0, locked_o 0, all rst_x_no 0; sequence then repeats cycle-identically.
REQ-034 Long run of 10^6 cycles -> enable counts equal F*10^6/RefClkFreq exactly for each domain: 500000, 480000, 250000.

Source files
------------

// File: rtl/sonata_clkgen.sv
// sonata_clkgen: fractional clock-enable generator with lock tracking.
// Three accumulator-based enables (sys, usb, peri) derived from clk_i, a lock
// counter, and one 2-stage reset synchroniser per domain that releases the
// domain reset in step with that domain's own enable once locked.
module sonata_clkgen #(
   parameter int unsigned RefClkFreq  = 100_000_000,
   parameter int unsigned SysClkFreq  = 50_000_000,
   parameter int unsigned UsbClkFreq  = 48_000_000,
   parameter int unsigned PeriClkFreq = 25_000_000,
   parameter int unsigned LockCycles  = 16
) (
   input  logic clk_i,
   input  logic rst_i,
   output logic clk_sys_en_o,
   output logic rst_sys_no,
   output logic clk_usb_en_o,
   output logic rst_usb_no,
   output logic clk_peri_en_o,
   output logic rst_peri_no,
   output logic locked_o
);

   localparam int unsigned     NumDom  = 3;
   localparam logic [31:0]     RefFreq = 32'(RefClkFreq);
   localparam logic [31:0]     DomFreq [NumDom] = '{32'(SysClkFreq), 32'(UsbClkFreq), 32'(PeriClkFreq)};
   localparam int unsigned     CntW    = $clog2(LockCycles + 1);
   localparam logic [CntW-1:0] LockMax = CntW'(LockCycles);

   if (SysClkFreq == 0 || SysClkFreq > RefClkFreq ||
       UsbClkFreq == 0 || UsbClkFreq > RefClkFreq ||
       PeriClkFreq == 0 || PeriClkFreq > RefClkFreq ||
       LockCycles == 0) begin : g_param_check
      $error("sonata_clkgen: each domain frequency must be in 1..RefClkFreq and LockCycles >= 1");
   end

   logic [CntW-1:0]   lock_cnt;
   logic              locked;
   logic [NumDom-1:0] en_vec;
   logic [NumDom-1:0] rst_vec;

   // Lock counter saturates at LockCycles; locked goes high on the edge the count reaches it and sticks
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         lock_cnt <= '0;
         locked   <= 1'b0;
      end else begin
         if (lock_cnt != LockMax) begin
            lock_cnt <= lock_cnt + 1'b1;
         end
         // lock_cnt == LockMax-1 here means this edge is the one that reaches LockMax
         if (lock_cnt >= LockMax - 1'b1) begin
            locked <= 1'b1;
         end
      end
   end

   for (genvar d = 0; d < NumDom; d++) begin : g_dom
      logic [31:0] acc;
      logic        en;
      logic [1:0]  rst_sr;
      logic [32:0] sum;

      // Next accumulator value, widened so acc + F cannot wrap
      always_comb sum = {1'b0, acc} + {1'b0, DomFreq[d]};

      // Accumulator enable plus reset synchroniser clocked by the registered enable
      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            acc    <= '0;
            en     <= 1'b0;
            rst_sr <= '0;
         end else begin
            if (sum >= {1'b0, RefFreq}) begin
               en  <= 1'b1;
               acc <= 32'(sum - {1'b0, RefFreq});
            end else begin
               en  <= 1'b0;
               acc <= sum[31:0];
            end
            if (!locked) begin
               rst_sr <= '0;
            end else if (en) begin
               rst_sr <= {rst_sr[0], 1'b1};
            end
         end
      end

      assign en_vec[d]  = en;
      assign rst_vec[d] = rst_sr[1];
   end

   assign clk_sys_en_o  = en_vec[0];
   assign clk_usb_en_o  = en_vec[1];
   assign clk_peri_en_o = en_vec[2];
   assign rst_sys_no    = rst_vec[0];
   assign rst_usb_no    = rst_vec[1];
   assign rst_peri_no   = rst_vec[2];
   assign locked_o      = locked;

endmodule

// File: tb/tb_sonata_clkgen.sv
// Directed bench for sonata_clkgen: a default-parameter instance plus a scaled
// instance (RefClkFreq=100, SysClkFreq=RefClkFreq, LockCycles=4), shared clock/reset.
module tb_sonata_clkgen;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic d_sys_en, d_sys_rst, d_usb_en, d_usb_rst, d_peri_en, d_peri_rst, d_locked;
   logic f_sys_en, f_sys_rst, f_usb_en, f_usb_rst, f_peri_en, f_peri_rst, f_locked;

   int n_cmp = 0;
   int n_err = 0;

   sonata_clkgen u_dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .clk_sys_en_o (d_sys_en),
      .rst_sys_no   (d_sys_rst),
      .clk_usb_en_o (d_usb_en),
      .rst_usb_no   (d_usb_rst),
      .clk_peri_en_o(d_peri_en),
      .rst_peri_no  (d_peri_rst),
      .locked_o     (d_locked)
   );

   sonata_clkgen #(
      .RefClkFreq (100),
      .SysClkFreq (100),
      .UsbClkFreq (48),
      .PeriClkFreq(25),
      .LockCycles (4)
   ) u_fast (
      .clk_i        (clk),
      .rst_i        (rst),
      .clk_sys_en_o (f_sys_en),
      .rst_sys_no   (f_sys_rst),
      .clk_usb_en_o (f_usb_en),
      .rst_usb_no   (f_usb_rst),
      .clk_peri_en_o(f_peri_en),
      .rst_peri_no  (f_peri_rst),
      .locked_o     (f_locked)
   );

   always #5 clk = ~clk;

   // Watchdog so the run always ends
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   typedef struct {
      int   k;
      logic sys, usb, peri, lock, rs, ru, rp;
      logic fsys, flock, frs;
   } vec_t;

   vec_t tbl [24];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Expects rst already low; checks edges 1..24 after release
   task automatic run_table(input string tag);
      logic [9:0] act, exp;
      for (int i = 0; i < 24; i++) begin
         @(posedge clk);
         @(negedge clk);
         act = {d_sys_en, d_usb_en, d_peri_en, d_locked, d_sys_rst, d_usb_rst, d_peri_rst,
                f_sys_en, f_locked, f_sys_rst};
         exp = {tbl[i].sys, tbl[i].usb, tbl[i].peri, tbl[i].lock, tbl[i].rs, tbl[i].ru, tbl[i].rp,
                tbl[i].fsys, tbl[i].flock, tbl[i].frs};
         check($sformatf("%s edge %0d", tag, tbl[i].k), 32'(act), 32'(exp));
      end
   endtask

   function automatic logic [13:0] all_outs();
      return {d_sys_en, d_sys_rst, d_usb_en, d_usb_rst, d_peri_en, d_peri_rst, d_locked,
              f_sys_en, f_sys_rst, f_usb_en, f_usb_rst, f_peri_en, f_peri_rst, f_locked};
   endfunction

   initial begin
      int c_sys, c_usb, c_peri, cf_sys, cf_usb, cf_peri, drops;

      //         k   sys usb peri lock rs ru rp  fsys flock frs
      tbl[0]  = '{1,  0,  0,  0,   0,   0, 0, 0,  1,   0,    0};
      tbl[1]  = '{2,  1,  0,  0,   0,   0, 0, 0,  1,   0,    0};
      tbl[2]  = '{3,  0,  1,  0,   0,   0, 0, 0,  1,   0,    0};
      tbl[3]  = '{4,  1,  0,  1,   0,   0, 0, 0,  1,   1,    0};
      tbl[4]  = '{5,  0,  1,  0,   0,   0, 0, 0,  1,   1,    0};
      tbl[5]  = '{6,  1,  0,  0,   0,   0, 0, 0,  1,   1,    1};
      tbl[6]  = '{7,  0,  1,  0,   0,   0, 0, 0,  1,   1,    1};
      tbl[7]  = '{8,  1,  0,  1,   0,   0, 0, 0,  1,   1,    1};
      tbl[8]  = '{9,  0,  1,  0,   0,   0, 0, 0,  1,   1,    1};
      tbl[9]  = '{10, 1,  0,  0,   0,   0, 0, 0,  1,   1,    1};
      tbl[10] = '{11, 0,  1,  0,   0,   0, 0, 0,  1,   1,    1};
      tbl[11] = '{12, 1,  0,  1,   0,   0, 0, 0,  1,   1,    1};
      tbl[12] = '{13, 0,  1,  0,   0,   0, 0, 0,  1,   1,    1};
      tbl[13] = '{14, 1,  0,  0,   0,   0, 0, 0,  1,   1,    1};
      tbl[14] = '{15, 0,  1,  0,   0,   0, 0, 0,  1,   1,    1};
      tbl[15] = '{16, 1,  0,  1,   1,   0, 0, 0,  1,   1,    1};
      tbl[16] = '{17, 0,  1,  0,   1,   0, 0, 0,  1,   1,    1};
      tbl[17] = '{18, 1,  0,  0,   1,   0, 0, 0,  1,   1,    1};
      tbl[18] = '{19, 0,  1,  0,   1,   1, 0, 0,  1,   1,    1};
      tbl[19] = '{20, 1,  0,  1,   1,   1, 1, 0,  1,   1,    1};
      tbl[20] = '{21, 0,  1,  0,   1,   1, 1, 1,  1,   1,    1};
      tbl[21] = '{22, 1,  0,  0,   1,   1, 1, 1,  1,   1,    1};
      tbl[22] = '{23, 0,  1,  0,   1,   1, 1, 1,  1,   1,    1};
      tbl[23] = '{24, 1,  0,  1,   1,   1, 1, 1,  1,   1,    1};

      // Reset held for three edges
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset state", 32'(all_outs()), 32'd0);

      rst = 1'b0;
      run_table("first");

      // Run on a bit, then a single-cycle reset mid-operation
      repeat (10) @(posedge clk);
      @(negedge clk);
      check("locked before mid reset", 32'({d_locked, d_sys_rst, d_usb_rst, d_peri_rst, f_locked, f_sys_rst}), 32'h3f);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("mid reset same edge", 32'(all_outs()), 32'd0);
      rst = 1'b0;
      run_table("repeat");

      // Long run from a fresh reset: exact pulse counts, no reset reassertion
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      c_sys = 0; c_usb = 0; c_peri = 0; cf_sys = 0; cf_usb = 0; cf_peri = 0; drops = 0;
      for (int k = 1; k <= 50000; k++) begin
         @(posedge clk);
         @(negedge clk);
         c_sys   += int'(d_sys_en);
         c_usb   += int'(d_usb_en);
         c_peri  += int'(d_peri_en);
         cf_sys  += int'(f_sys_en);
         cf_usb  += int'(f_usb_en);
         cf_peri += int'(f_peri_en);
         if (k > 21 && !(d_locked && d_sys_rst && d_usb_rst && d_peri_rst)) drops++;
         if (k > 9 && !(f_locked && f_sys_rst && f_usb_rst && f_peri_rst)) drops++;
      end
      check("count sys 50k",      32'(c_sys),   32'd25000);
      check("count usb 50k",      32'(c_usb),   32'd24000);
      check("count peri 50k",     32'(c_peri),  32'd12500);
      check("fast count sys 50k", 32'(cf_sys),  32'd50000);
      check("fast count usb 50k", 32'(cf_usb),  32'd24000);
      check("fast count peri 50k",32'(cf_peri), 32'd12500);
      check("no reset reassert",  32'(drops),   32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
